// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller for the 5-stage core. It resolves
//            load-use stalls, taken-branch flushes and data-memory wait
//            freezes. It also keeps saturating stall/flush counters and a
//            sticky memory-timeout flag for debug.
// Ports    :
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   IDEX_MemRead      ID/EX instruction is a load
//   IDEX_rd           ID/EX destination register
//   IFID_rs1/rs2      IF/ID source registers
//   IFID_uses_rs2     IF/ID instruction reads rs2
//   branch_taken      EX resolved a taken branch/jump
//   mem_busy          data memory not ready this cycle
//   PCWrite           PC update enable
//   IFIDWrite         IF/ID load enable
//   IFIDFlush         IF/ID loads NOP
//   IDEXFlush         ID/EX loads bubble
//   PipeHold          freeze ID/EX, EX/MEM, MEM/WB
//   stall_count       load-use stall cycles (saturating)
//   flush_count       branch flush events (saturating)
//   mem_timeout       sticky memory-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_rd,
  input  logic [REG_ADDR_W-1:0] IFID_rs1,
  input  logic [REG_ADDR_W-1:0] IFID_rs2,
  input  logic                  IFID_uses_rs2,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  IFIDFlush,
  output logic                  IDEXFlush,
  output logic                  PipeHold,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count,
  output logic                  mem_timeout
);

  localparam int                  c_TMR_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_TMR_W-1:0]  c_TMR_MAX = c_TMR_W'(MEM_TIMEOUT);
  localparam logic [c_TMR_W-1:0]  c_TMR_SET = c_TMR_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_TMR_W-1:0]  r_timer;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic                r_timeout;

  logic w_lu;
  logic w_rule_flush;
  logic w_rule_stall;

  // A load to x0 never creates a dependency, so rd==0 is excluded.
  assign w_lu = IDEX_MemRead && (IDEX_rd != '0) &&
                ((IDEX_rd == IFID_rs1) ||
                 (IFID_uses_rs2 && (IDEX_rd == IFID_rs2)));

  // A memory wait freezes EX and ID, so a branch or load-use seen under
  // mem_busy is not acted on; it is re-evaluated once memory is ready.
  assign w_rule_flush = !mem_busy && branch_taken;
  assign w_rule_stall = !mem_busy && !branch_taken && w_lu;

  // Mealy control outputs, prioritised: mem wait > branch > load-use.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    PipeHold  = 1'b0;
    if (!rst_n) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (mem_busy) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      PipeHold  = 1'b1;
    end else if (branch_taken) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (w_lu) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (mem_busy) begin
      w_state_nxt = MEM_WAIT;
    end else begin
      case (r_state)
        RUN:      w_state_nxt = (w_lu && !branch_taken) ? LU_STALL : RUN;
        LU_STALL: w_state_nxt = RUN;
        MEM_WAIT: w_state_nxt = RUN;
        default:  w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_rule_stall && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_rule_flush && (r_flush_cnt != c_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  // The flag sets on the same edge the timer reaches MEM_TIMEOUT, i.e. after
  // MEM_TIMEOUT consecutive busy cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else if (mem_busy) begin
      if (r_timer != c_TMR_MAX) begin
        r_timer <= r_timer + 1'b1;
      end
      if (r_timer >= c_TMR_SET) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_timer <= '0;
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
  assign mem_timeout = r_timeout;

endmodule
`default_nettype wire
